// File: rtl/cpu5_muldiv.sv
// cpu5_muldiv: iterative RV32M multiply/divide unit for the cpu5 execute stage.
// One radix-2 step per cycle (shift-add multiply, restoring divide) behind a
// valid/ready request/response handshake. Signed operands are converted to
// magnitudes on accept and the recorded sign is applied on the final step.
module cpu5_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [2*XLEN-1:0]   prod_q, prod_d;
   logic [XLEN-1:0]     rem_q, rem_d;
   logic [XLEN-1:0]     opb_q, opb_d;
   logic                neg_q, neg_d;
   logic [XLEN-1:0]     result_q, result_d;

   logic                accept;
   logic                sign1, sign2;
   logic [XLEN-1:0]     abs1, abs2;
   logic [XLEN:0]       mul_sum;
   logic [2*XLEN-1:0]   mul_next;
   logic [XLEN:0]       div_shift, div_diff;
   logic                div_borrow;
   logic [XLEN-1:0]     rem_next, quo_next;
   logic [2*XLEN-1:0]   prod_signed;
   logic [XLEN-1:0]     quo_signed, rem_signed, calc_result;

   assign req_ready  = (state_q == S_IDLE) & ~flush;
   assign accept     = req_valid & req_ready;
   assign resp_valid = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign result     = result_q;

   assign sign1 = src1[XLEN-1];
   assign sign2 = src2[XLEN-1];
   assign abs1  = sign1 ? -src1 : src1;
   assign abs2  = sign2 ? -src2 : src2;

   // One iteration of either algorithm, plus the sign-corrected result it would yield if it were the last
   always_comb begin
      mul_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} + ({1'b0, opb_q} & {(XLEN+1){prod_q[0]}});
      mul_next    = {mul_sum, prod_q[XLEN-1:1]};
      div_shift   = {rem_q, prod_q[XLEN-1]};
      div_diff    = div_shift - {1'b0, opb_q};
      div_borrow  = div_diff[XLEN];
      rem_next    = div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
      quo_next    = {prod_q[XLEN-2:0], ~div_borrow};
      prod_signed = neg_q ? -mul_next : mul_next;
      quo_signed  = neg_q ? -quo_next : quo_next;
      rem_signed  = neg_q ? -rem_next : rem_next;
      if (op_q[2]) begin
         calc_result = op_q[1] ? rem_signed : quo_signed;
      end else if (op_q[1:0] == 2'b00) begin
         calc_result = prod_signed[XLEN-1:0];
      end else begin
         calc_result = prod_signed[2*XLEN-1:XLEN];
      end
   end

   // Next-state and datapath loads: operand prep on accept, iteration in CALC, handoff in DONE
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      rem_d    = rem_q;
      opb_d    = opb_q;
      neg_d    = neg_q;
      result_d = result_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               op_d    = funct3;
               cnt_d   = CNT_W'(XLEN);
               rem_d   = '0;
               state_d = S_CALC;
               case (funct3)
                  3'b001: begin
                     prod_d = {{XLEN{1'b0}}, abs1};
                     opb_d  = abs2;
                     neg_d  = sign1 ^ sign2;
                  end
                  3'b010: begin
                     prod_d = {{XLEN{1'b0}}, abs1};
                     opb_d  = src2;
                     neg_d  = sign1;
                  end
                  3'b100, 3'b110: begin
                     prod_d = {{XLEN{1'b0}}, abs1};
                     opb_d  = abs2;
                     neg_d  = funct3[1] ? sign1 : (sign1 ^ sign2);
                  end
                  default: begin
                     prod_d = {{XLEN{1'b0}}, src1};
                     opb_d  = src2;
                     neg_d  = 1'b0;
                  end
               endcase
               if (funct3[2] && (src2 == '0)) begin
                  state_d  = S_DONE;
                  result_d = funct3[1] ? src1 : '1;
               end else if (funct3[2] && !funct3[0] && (src1 == MIN_NEG) && (src2 == '1)) begin
                  state_d  = S_DONE;
                  result_d = funct3[1] ? '0 : src1;
               end
            end
         end
         S_CALC: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q[2]) begin
               prod_d = {prod_q[2*XLEN-1:XLEN], quo_next};
               rem_d  = rem_next;
            end else begin
               prod_d = mul_next;
            end
            if (cnt_q == CNT_W'(1)) begin
               state_d  = S_DONE;
               result_d = calc_result;
            end
         end
         S_DONE: begin
            if (resp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
      end
   end

   // State and datapath registers, cleared by the asynchronous reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         rem_q    <= '0;
         opb_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         rem_q    <= rem_d;
         opb_q    <= opb_d;
         neg_q    <= neg_d;
         result_q <= result_d;
      end
   end

endmodule

// File: tb/tb_cpu5_muldiv.sv
// tb_cpu5_muldiv: directed and randomized checks of cpu5_muldiv at XLEN=32 and XLEN=8.
module tb_cpu5_muldiv;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  funct3;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] result;
   logic        busy;

   logic        flush8;
   logic        req_valid8;
   logic        req_ready8;
   logic [2:0]  funct3_8;
   logic [7:0]  src1_8;
   logic [7:0]  src2_8;
   logic        resp_valid8;
   logic        resp_ready8;
   logic [7:0]  result8;
   logic        busy8;

   int checks = 0;
   int errors = 0;

   cpu5_muldiv #(.XLEN(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .funct3(funct3), .src1(src1), .src2(src2),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .result(result), .busy(busy)
   );

   cpu5_muldiv #(.XLEN(8), .CNT_W(6)) dut8 (
      .clk(clk), .reset(reset), .flush(flush8),
      .req_valid(req_valid8), .req_ready(req_ready8),
      .funct3(funct3_8), .src1(src1_8), .src2(src2_8),
      .resp_valid(resp_valid8), .resp_ready(resp_ready8),
      .result(result8), .busy(busy8)
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent arithmetic reference for width w (w <= 32), built on 64-bit integer arithmetic
   function automatic logic [31:0] ref_op(input int w, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] b);
      longint      ua, ub, sa, sb, min_s;
      logic [63:0] full;
      logic [63:0] mask;
      bit          hi;
      mask  = (64'd1 << w) - 64'd1;
      ua    = longint'(a);
      ub    = longint'(b);
      sa    = a[w-1] ? ua - (longint'(1) << w) : ua;
      sb    = b[w-1] ? ub - (longint'(1) << w) : ub;
      min_s = -(longint'(1) << (w - 1));
      hi    = 1'b0;
      full  = '0;
      case (f3)
         3'd0: full = ua * ub;
         3'd1: begin full = sa * sb; hi = 1'b1; end
         3'd2: begin full = sa * ub; hi = 1'b1; end
         3'd3: begin full = ua * ub; hi = 1'b1; end
         3'd4: begin
            if (ub == 0) full = '1;
            else if (sa == min_s && sb == -1) full = ua;
            else full = sa / sb;
         end
         3'd5: full = (ub == 0) ? '1 : ua / ub;
         3'd6: begin
            if (ub == 0) full = ua;
            else if (sa == min_s && sb == -1) full = '0;
            else full = sa % sb;
         end
         default: full = (ub == 0) ? ua : ua % ub;
      endcase
      if (hi) full = full >> w;
      return 32'(full & mask);
   endfunction

   // Issue one op to the 32-bit unit; called #1 after a clock edge with the unit idle
   task automatic run32(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit handoff, output logic [31:0] res, output int lat);
      funct3 = f3; src1 = a; src2 = b; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat >= 100) begin
         errors++;
         $display("[TB] FAIL run32_timeout op=%0d got no resp_valid want resp_valid within 100 cycles", f3);
      end
      res = result;
      if (handoff) begin
         resp_ready = 1'b1;
         @(posedge clk); #1;
         resp_ready = 1'b0;
      end
   endtask

   // Issue one op to the 8-bit unit and hand the response off
   task automatic run8(input logic [2:0] f3, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] res);
      int lat;
      funct3_8 = f3; src1_8 = a; src2_8 = b; req_valid8 = 1'b1;
      @(posedge clk); #1;
      req_valid8 = 1'b0;
      lat = 0;
      while (resp_valid8 !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat >= 100) begin
         errors++;
         $display("[TB] FAIL run8_timeout op=%0d got no resp_valid want resp_valid within 100 cycles", f3);
      end
      res = result8;
      resp_ready8 = 1'b1;
      @(posedge clk); #1;
      resp_ready8 = 1'b0;
   endtask

   // Outputs while reset is held, then release
   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_req_ready got %b want 1", req_ready); end
      checks++;
      if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid got %b want 0", resp_valid); end
      checks++;
      if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 00000000", result); end
      checks++;
      if (busy !== 1'b0 || busy8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b/%b want 0/0", busy, busy8); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   // Multiply variants including the low/high product halves and sign handling
   task automatic test_mul();
      logic [31:0] r;
      int          lat;
      run32(3'b000, 32'd7, 32'hFFFFFFFD, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mul_7x-3 got %h want ffffffeb", r); end
      checks++;
      if (lat !== 32) begin errors++; $display("[TB] FAIL mul_latency got %0d want 32 edges after accept", lat); end
      run32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFFE) begin errors++; $display("[TB] FAIL mulhu_max got %h want fffffffe", r); end
      run32(3'b001, 32'h80000000, 32'h80000000, 1'b1, r, lat);
      checks++;
      if (r !== 32'h40000000) begin errors++; $display("[TB] FAIL mulh_min got %h want 40000000", r); end
      run32(3'b010, 32'hFFFFFFFF, 32'h00000002, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL mulhsu_-1x2 got %h want ffffffff", r); end
   endtask

   // Signed and unsigned divide / remainder through the iterative path
   task automatic test_div();
      logic [31:0] r;
      int          lat;
      run32(3'b100, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_-7/2 got %h want fffffffd", r); end
      checks++;
      if (lat !== 32) begin errors++; $display("[TB] FAIL div_latency got %0d want 32", lat); end
      run32(3'b110, 32'hFFFFFFF9, 32'd2, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL rem_-7/2 got %h want ffffffff", r); end
      run32(3'b101, 32'd100, 32'd7, 1'b1, r, lat);
      checks++;
      if (r !== 32'd14) begin errors++; $display("[TB] FAIL divu_100/7 got %0d want 14", r); end
      run32(3'b111, 32'd100, 32'd7, 1'b1, r, lat);
      checks++;
      if (r !== 32'd2) begin errors++; $display("[TB] FAIL remu_100/7 got %0d want 2", r); end
   endtask

   // Divide-by-zero and signed overflow complete without iterating
   task automatic test_fast_path();
      logic [31:0] r;
      int          lat;
      run32(3'b100, 32'd5, 32'd0, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFFF || lat !== 0) begin errors++; $display("[TB] FAIL div_by_zero got %h lat %0d want ffffffff lat 0", r, lat); end
      run32(3'b110, 32'd5, 32'd0, 1'b1, r, lat);
      checks++;
      if (r !== 32'd5 || lat !== 0) begin errors++; $display("[TB] FAIL rem_by_zero got %h lat %0d want 00000005 lat 0", r, lat); end
      run32(3'b100, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
      checks++;
      if (r !== 32'h80000000 || lat !== 0) begin errors++; $display("[TB] FAIL div_overflow got %h lat %0d want 80000000 lat 0", r, lat); end
      run32(3'b110, 32'h80000000, 32'hFFFFFFFF, 1'b1, r, lat);
      checks++;
      if (r !== 32'h0 || lat !== 0) begin errors++; $display("[TB] FAIL rem_overflow got %h lat %0d want 00000000 lat 0", r, lat); end
      run32(3'b101, 32'd9, 32'd0, 1'b1, r, lat);
      checks++;
      if (r !== 32'hFFFFFFFF || lat !== 0) begin errors++; $display("[TB] FAIL divu_by_zero got %h lat %0d want ffffffff lat 0", r, lat); end
   endtask

   // Response held while the consumer stalls; a pending request waits for the handoff
   task automatic test_hold();
      logic [31:0] r;
      int          lat;
      run32(3'b101, 32'd100, 32'd7, 1'b0, r, lat);
      funct3 = 3'b000; src1 = 32'd3; src2 = 32'd3; req_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (resp_valid !== 1'b1 || result !== 32'd14 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_cycle%0d got valid=%b result=%0d req_ready=%b want 1/14/0", i, resp_valid, result, req_ready);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL handoff got valid=%b req_ready=%b busy=%b want 0/1/0", resp_valid, req_ready, busy);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("[TB] FAIL accept_after_handoff got busy=%b want 1", busy); end
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (result !== 32'd9 || resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL post_handoff_mul got %0d valid=%b want 9 valid=1", result, resp_valid); end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
   endtask

   // Flush in the middle of CALC, racing a new request
   task automatic test_flush();
      bit seen;
      funct3 = 3'b101; src1 = 32'd1000; src2 = 32'd3; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      flush = 1'b1; req_valid = 1'b1; funct3 = 3'b000; src1 = 32'd2; src2 = 32'd2;
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("[TB] FAIL flush_req_ready got %b want 0", req_ready); end
      @(posedge clk); #1;
      flush = 1'b0; req_valid = 1'b0;
      checks++;
      if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_idle got busy=%b valid=%b want 0/0", busy, resp_valid); end
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen) begin errors++; $display("[TB] FAIL flush_no_response got activity=1 want 0"); end
      checks++;
      if (result !== 32'd9) begin errors++; $display("[TB] FAIL flush_result_kept got %0d want 9", result); end
   endtask

   // Asynchronous reset in the middle of a divide, then recovery
   task automatic test_async_reset();
      logic [31:0] r;
      int          lat;
      funct3 = 3'b100; src1 = 32'd1000; src2 = 32'hFFFFFFFD; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || result !== 32'h0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL async_reset got ready=%b valid=%b result=%h busy=%b want 1/0/00000000/0", req_ready, resp_valid, result, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;
      run32(3'b000, 32'd6, 32'd7, 1'b1, r, lat);
      checks++;
      if (r !== 32'd42) begin errors++; $display("[TB] FAIL after_reset_mul got %0d want 42", r); end
   endtask

   // Back-to-back operations against the reference at both widths
   task automatic test_back_to_back();
      logic [31:0] r, a, b, exp;
      logic [7:0]  r8, a8, b8;
      logic [2:0]  f3;
      int          lat;
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = $urandom;
         b  = (i % 5 == 0) ? 32'd0 : $urandom;
         if (i % 7 == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         exp = ref_op(32, f3, a, b);
         run32(f3, a, b, 1'b1, r, lat);
         checks++;
         if (r !== exp) begin errors++; $display("[TB] FAIL rand32_%0d op=%0d a=%h b=%h got %h want %h", i, f3, a, b, r, exp); end
      end
      for (int i = 0; i < 24; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a8 = 8'($urandom);
         b8 = (i % 5 == 0) ? 8'd0 : 8'($urandom);
         if (i % 7 == 3) begin a8 = 8'h80; b8 = 8'hFF; end
         exp = ref_op(8, f3, {24'd0, a8}, {24'd0, b8});
         run8(f3, a8, b8, r8);
         checks++;
         if (r8 !== exp[7:0]) begin errors++; $display("[TB] FAIL rand8_%0d op=%0d a=%h b=%h got %h want %h", i, f3, a8, b8, r8, exp[7:0]); end
      end
   endtask

   // Scenario sequence and summary
   initial begin
      reset = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
      funct3 = 3'b000; src1 = '0; src2 = '0;
      flush8 = 1'b0; req_valid8 = 1'b0; resp_ready8 = 1'b0;
      funct3_8 = 3'b000; src1_8 = '0; src2_8 = '0;
      test_reset();
      test_mul();
      test_div();
      test_fast_path();
      test_hold();
      test_flush();
      test_async_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
